// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the regfile write-back controller: sizes,
// halfword-enable bit positions and the write-port requester encoding.
package regfile_wb_ctrl_pkg;

   localparam int WB_AW         = 3;
   localparam int WB_DATA_W     = 32;
   localparam int WB_NREG       = 8;
   localparam int WB_STARVE_MAX = 3;

   // Width of the ALU starvation counter.
   localparam int WB_STARVE_W   = 2;

   // Width of each per-register pending-write counter.
   localparam int WB_CNT_W      = 2;

   // Bit positions inside a 2-bit halfword enable.
   localparam int WB_BE_L       = 0;
   localparam int WB_BE_H       = 1;

   // Which requester owns the write port in the current cycle.
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_ALU  = 2'd1,
      REQ_MEM  = 2'd2
   } req_t;

endpackage

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Pending-write scoreboard: one small saturating counter per register,
// raised on issue and lowered on write-back, feeding decode with a
// read-hazard flag and the issue stage with a back-pressure signal.
module wb_scoreboard
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int NREG = WB_NREG,
   parameter int AW   = WB_AW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_wa,
   output logic          issue_ready,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_wa,
   input  logic [AW-1:0] ra0,
   input  logic [AW-1:0] ra1,
   output logic          hazard,
   output logic          sb_err
);

   localparam logic [WB_CNT_W-1:0] CNT_MAX = '1;

   logic [WB_CNT_W-1:0] cnt_arr [NREG];
   logic                issue_fire;
   logic                err_hit;
   logic                sb_err_reg;

   // A full counter cannot absorb another issue; the issue must wait.
   assign issue_ready = (cnt_arr[issue_wa] != CNT_MAX);
   assign issue_fire  = issue_valid && issue_ready;
   assign hazard      = (cnt_arr[ra0] != '0) || (cnt_arr[ra1] != '0);
   assign err_hit     = wb_valid && (cnt_arr[wb_wa] == '0);
   assign sb_err      = sb_err_reg;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
         logic                inc;
         logic                dec_hit;
         logic [WB_CNT_W-1:0] cnt_reg;
         logic [WB_CNT_W-1:0] cnt_next;

         assign inc     = issue_fire && (issue_wa == AW'(gi));
         assign dec_hit = wb_valid && (wb_wa == AW'(gi));
         assign cnt_arr[gi] = cnt_reg;

         // Issue and retire on the same edge cancel; a retire at zero is
         // an error and leaves the count at zero.
         always_comb begin
            cnt_next = cnt_reg;
            if (inc && !dec_hit) begin
               cnt_next = cnt_reg + WB_CNT_W'(1);
            end else if (dec_hit && !inc && (cnt_reg != '0)) begin
               cnt_next = cnt_reg - WB_CNT_W'(1);
            end
         end

         // Counter register, cleared by the asynchronous reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
      end
   endgenerate

   // Sticky error flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_err_reg <= 1'b0;
      end else if (err_hit) begin
         sb_err_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the register file: arbitrates the single
// write port between the ALU and load paths (load preferred, with an
// anti-starvation override for the ALU), registers the write onto the
// regfile port and tracks outstanding writes in a scoreboard.
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int NREG       = WB_NREG,
   parameter int AW         = WB_AW,
   parameter int STARVE_MAX = WB_STARVE_MAX
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              ALU_VALID,
   input  logic [AW-1:0]     ALU_WA,
   input  logic [DATA_W-1:0] ALU_DATA,
   input  logic [1:0]        ALU_BE,
   output logic              ALU_READY,
   input  logic              MEM_VALID,
   input  logic [AW-1:0]     MEM_WA,
   input  logic [DATA_W-1:0] MEM_DATA,
   input  logic [1:0]        MEM_BE,
   output logic              MEM_READY,
   input  logic              ISSUE_VALID,
   input  logic [AW-1:0]     ISSUE_WA,
   output logic              ISSUE_READY,
   input  logic [AW-1:0]     RA0,
   input  logic [AW-1:0]     RA1,
   output logic              HAZARD,
   output logic [AW-1:0]     RF_WA,
   output logic [DATA_W-1:0] RF_IN,
   output logic              RF_WE_L,
   output logic              RF_WE_H,
   output logic              SB_ERR
);

   req_t                   grant;
   logic                   wb_fire;
   logic [WB_STARVE_W-1:0] starve_cnt_reg;
   logic [WB_STARVE_W-1:0] starve_cnt_next;
   logic [AW-1:0]          sel_wa;
   logic [DATA_W-1:0]      sel_data;
   logic [1:0]             sel_be;
   logic [AW-1:0]          rf_wa_reg;
   logic [DATA_W-1:0]      rf_in_reg;
   logic                   rf_we_l_reg;
   logic                   rf_we_h_reg;

   // Grant selection: load wins conflicts unless the ALU has lost enough in a row.
   always_comb begin
      grant = REQ_NONE;
      if (ALU_VALID && MEM_VALID) begin
         if (starve_cnt_reg == WB_STARVE_W'(STARVE_MAX)) begin
            grant = REQ_ALU;
         end else begin
            grant = REQ_MEM;
         end
      end else if (ALU_VALID) begin
         grant = REQ_ALU;
      end else if (MEM_VALID) begin
         grant = REQ_MEM;
      end
   end

   assign ALU_READY = (grant == REQ_ALU);
   assign MEM_READY = (grant == REQ_MEM);
   assign wb_fire   = (grant != REQ_NONE);

   // Count consecutive ALU conflict losses; any ALU grant or idle ALU restarts it.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!ALU_VALID || (grant == REQ_ALU)) begin
         starve_cnt_next = '0;
      end else begin
         starve_cnt_next = starve_cnt_reg + WB_STARVE_W'(1);
      end
   end

   // Steer the granted requester's fields toward the output stage and scoreboard.
   always_comb begin
      sel_wa   = ALU_WA;
      sel_data = ALU_DATA;
      sel_be   = ALU_BE;
      if (grant == REQ_MEM) begin
         sel_wa   = MEM_WA;
         sel_data = MEM_DATA;
         sel_be   = MEM_BE;
      end
   end

   // Starvation counter register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   // Output stage: load the regfile port on a grant, otherwise drop the enables
   // and let address/data hold so the port stays quiet.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rf_wa_reg   <= '0;
         rf_in_reg   <= '0;
         rf_we_l_reg <= 1'b0;
         rf_we_h_reg <= 1'b0;
      end else if (wb_fire) begin
         rf_wa_reg   <= sel_wa;
         rf_in_reg   <= sel_data;
         rf_we_l_reg <= sel_be[WB_BE_L];
         rf_we_h_reg <= sel_be[WB_BE_H];
      end else begin
         rf_we_l_reg <= 1'b0;
         rf_we_h_reg <= 1'b0;
      end
   end

   assign RF_WA   = rf_wa_reg;
   assign RF_IN   = rf_in_reg;
   assign RF_WE_L = rf_we_l_reg;
   assign RF_WE_H = rf_we_h_reg;

   // A granted write-back retires one pending write even when BE is 00.
   wb_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk         (CLK),
      .rst         (RST),
      .issue_valid (ISSUE_VALID),
      .issue_wa    (ISSUE_WA),
      .issue_ready (ISSUE_READY),
      .wb_valid    (wb_fire),
      .wb_wa       (sel_wa),
      .ra0         (RA0),
      .ra1         (RA1),
      .hazard      (HAZARD),
      .sb_err      (SB_ERR)
   );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: reset values, a table of arbitration/output
// vectors, hand-written scoreboard sequences and a randomized run against
// a behavioural model.
module tb_regfile_wb_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ALU_VALID = 1'b0;
   logic [2:0]  ALU_WA = '0;
   logic [31:0] ALU_DATA = '0;
   logic [1:0]  ALU_BE = '0;
   logic        ALU_READY;
   logic        MEM_VALID = 1'b0;
   logic [2:0]  MEM_WA = '0;
   logic [31:0] MEM_DATA = '0;
   logic [1:0]  MEM_BE = '0;
   logic        MEM_READY;
   logic        ISSUE_VALID = 1'b0;
   logic [2:0]  ISSUE_WA = '0;
   logic        ISSUE_READY;
   logic [2:0]  RA0 = '0;
   logic [2:0]  RA1 = '0;
   logic        HAZARD;
   logic [2:0]  RF_WA;
   logic [31:0] RF_IN;
   logic        RF_WE_L;
   logic        RF_WE_H;
   logic        SB_ERR;

   int total = 0;
   int bad   = 0;

   regfile_wb_ctrl dut (
      .CLK(CLK), .RST(RST),
      .ALU_VALID(ALU_VALID), .ALU_WA(ALU_WA), .ALU_DATA(ALU_DATA), .ALU_BE(ALU_BE), .ALU_READY(ALU_READY),
      .MEM_VALID(MEM_VALID), .MEM_WA(MEM_WA), .MEM_DATA(MEM_DATA), .MEM_BE(MEM_BE), .MEM_READY(MEM_READY),
      .ISSUE_VALID(ISSUE_VALID), .ISSUE_WA(ISSUE_WA), .ISSUE_READY(ISSUE_READY),
      .RA0(RA0), .RA1(RA1), .HAZARD(HAZARD),
      .RF_WA(RF_WA), .RF_IN(RF_IN), .RF_WE_L(RF_WE_L), .RF_WE_H(RF_WE_H), .SB_ERR(SB_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ALU_VALID = 1'b0; MEM_VALID = 1'b0; ISSUE_VALID = 1'b0;
      RA0 = '0; RA1 = '0; ISSUE_WA = '0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      #1 RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      tick();
   endtask

   // ---------------- behavioural model ----------------
   int          m_cnt [8];
   int          m_loss;
   bit          m_err;
   logic [2:0]  m_wa;
   logic [31:0] m_in;
   bit          m_wel, m_weh;

   task automatic model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_loss = 0; m_err = 0; m_wa = '0; m_in = '0; m_wel = 0; m_weh = 0;
   endtask

   // 0 = nobody, 1 = ALU, 2 = MEM
   function automatic int model_grant();
      if (ALU_VALID && MEM_VALID) return (m_loss >= 3) ? 1 : 2;
      if (ALU_VALID) return 1;
      if (MEM_VALID) return 2;
      return 0;
   endfunction

   task automatic model_commit(input int g);
      bit          inc;
      bit          dec;
      int          iwa;
      int          dwa;
      logic [31:0] d;
      logic [1:0]  be;
      inc = ISSUE_VALID && (m_cnt[ISSUE_WA] != 3);
      iwa = int'(ISSUE_WA);
      dec = (g != 0);
      dwa = (g == 2) ? int'(MEM_WA) : int'(ALU_WA);
      d   = (g == 2) ? MEM_DATA : ALU_DATA;
      be  = (g == 2) ? MEM_BE : ALU_BE;
      if (dec && m_cnt[dwa] == 0) m_err = 1;
      if (!(inc && dec && iwa == dwa)) begin
         if (inc) m_cnt[iwa] = m_cnt[iwa] + 1;
         if (dec && m_cnt[dwa] > 0) m_cnt[dwa] = m_cnt[dwa] - 1;
      end
      if (!ALU_VALID || g == 1) m_loss = 0;
      else m_loss = m_loss + 1;
      if (dec) begin
         m_wa = 3'(dwa); m_in = d; m_wel = be[0]; m_weh = be[1];
      end else begin
         m_wel = 0; m_weh = 0;
      end
   endtask

   task automatic run_cycle(input int c, output int g);
      #1;
      g = model_grant();
      chk("rnd.alu_ready", ALU_READY, (g == 1));
      chk("rnd.mem_ready", MEM_READY, (g == 2));
      chk("rnd.issue_ready", ISSUE_READY, (m_cnt[ISSUE_WA] != 3));
      chk("rnd.hazard", HAZARD, (m_cnt[RA0] != 0) || (m_cnt[RA1] != 0));
      @(posedge CLK);
      model_commit(g);
      #1;
      chk("rnd.we_l", RF_WE_L, m_wel);
      chk("rnd.we_h", RF_WE_H, m_weh);
      chk("rnd.rf_wa", RF_WA, m_wa);
      chk("rnd.rf_in", RF_IN, m_in);
      chk("rnd.sb_err", SB_ERR, m_err);
      if (g != 0)
         $display("rnd c=%0d src=%s wa=%0d data=%h we=%b%b", c, (g == 1) ? "alu" : "mem", m_wa, m_in, m_weh, m_wel);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        av;  logic [2:0] awa; logic [31:0] ad; logic [1:0] abe;
      logic        mv;  logic [2:0] mwa; logic [31:0] md; logic [1:0] mbe;
      logic        e_ar; logic e_mr;
      logic [2:0]  e_wa; logic [31:0] e_in; logic e_wl; logic e_wh;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic av, input logic [2:0] awa, input logic [31:0] ad, input logic [1:0] abe,
                       input logic mv, input logic [2:0] mwa, input logic [31:0] md, input logic [1:0] mbe,
                       input logic e_ar, input logic e_mr, input logic [2:0] e_wa, input logic [31:0] e_in,
                       input logic e_wl, input logic e_wh);
      vec_t v;
      v.av = av; v.awa = awa; v.ad = ad; v.abe = abe;
      v.mv = mv; v.mwa = mwa; v.md = md; v.mbe = mbe;
      v.e_ar = e_ar; v.e_mr = e_mr; v.e_wa = e_wa; v.e_in = e_in; v.e_wl = e_wl; v.e_wh = e_wh;
      vecs.push_back(v);
   endtask

   localparam logic [31:0] DA = 32'hA0A0_A0A0;
   localparam logic [31:0] DM = 32'hB1B1_B1B1;

   initial begin
      int   g;
      vec_t v;

      model_reset();
      reset_dut();

      // reset state
      #1;
      chk("rst.alu_ready", ALU_READY, 0);
      chk("rst.mem_ready", MEM_READY, 0);
      chk("rst.issue_ready", ISSUE_READY, 1);
      chk("rst.hazard", HAZARD, 0);
      chk("rst.we_l", RF_WE_L, 0);
      chk("rst.we_h", RF_WE_H, 0);
      chk("rst.rf_wa", RF_WA, 0);
      chk("rst.rf_in", RF_IN, 0);
      chk("rst.sb_err", SB_ERR, 0);

      // av awa ad abe | mv mwa md mbe | ar mr | wa in wl wh
      addv(1, 5, 32'hDEADBEEF, 2'b11,  0, 0, 0, 2'b00,  1, 0,  5, 32'hDEADBEEF, 1, 1);
      addv(0, 0, 0, 2'b00,             0, 0, 0, 2'b00,  0, 0,  5, 32'hDEADBEEF, 0, 0);
      addv(0, 0, 0, 2'b00,  1, 1, 32'h12345678, 2'b10,  0, 1,  1, 32'h12345678, 0, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  1, 0,  3, DA, 1, 0);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 2, 32'h55, 2'b00,  0, 0, 0, 2'b00,  1, 0,  2, 32'h55, 0, 0);
      addv(0, 0, 0, 2'b00,             0, 0, 0, 2'b00,  0, 0,  2, 32'h55, 0, 0);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(0, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  0, 1,  6, DM, 1, 1);
      addv(1, 3, DA, 2'b01,  1, 6, DM, 2'b11,  1, 0,  3, DA, 1, 0);
      addv(0, 0, 0, 2'b00,  1, 0, 32'hCAFEF00D, 2'b01,  0, 1,  0, 32'hCAFEF00D, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         ALU_VALID = v.av; ALU_WA = v.awa; ALU_DATA = v.ad; ALU_BE = v.abe;
         MEM_VALID = v.mv; MEM_WA = v.mwa; MEM_DATA = v.md; MEM_BE = v.mbe;
         #1;
         chk($sformatf("vec%0d.alu_ready", i), ALU_READY, v.e_ar);
         chk($sformatf("vec%0d.mem_ready", i), MEM_READY, v.e_mr);
         tick();
         chk($sformatf("vec%0d.rf_wa", i), RF_WA, v.e_wa);
         chk($sformatf("vec%0d.rf_in", i), RF_IN, v.e_in);
         chk($sformatf("vec%0d.we_l", i), RF_WE_L, v.e_wl);
         chk($sformatf("vec%0d.we_h", i), RF_WE_H, v.e_wh);
         $display("vec %0d alu=%b mem=%b -> wa=%0d in=%h we=%b%b", i, v.av, v.mv, RF_WA, RF_IN, RF_WE_H, RF_WE_L);
      end
      idle_inputs();

      // scoreboard saturation on r2, then three retires
      reset_dut();
      ISSUE_VALID = 1; ISSUE_WA = 2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sat.issue_ready_pre", ISSUE_READY, 1);
         tick();
      end
      #1;
      chk("sat.issue_ready_full", ISSUE_READY, 0);
      RA0 = 2;
      #1;
      chk("sat.hazard_full", HAZARD, 1);
      tick();
      ISSUE_VALID = 0;
      ALU_VALID = 1; ALU_WA = 2; ALU_DATA = 32'h0000_0022; ALU_BE = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sat.alu_ready", ALU_READY, 1);
         tick();
         chk($sformatf("sat.hazard_after_wb%0d", k), HAZARD, (k < 2));
         chk($sformatf("sat.issue_ready_after_wb%0d", k), ISSUE_READY, 1);
      end
      ALU_VALID = 0;
      chk("sat.sb_err", SB_ERR, 0);
      $display("seq saturate r2 done");

      // simultaneous issue and retire on r4 with one pending
      ISSUE_VALID = 1; ISSUE_WA = 4;
      tick();
      ALU_VALID = 1; ALU_WA = 4; ALU_DATA = 32'h0000_0044; ALU_BE = 2'b11;
      #1;
      chk("sim.alu_ready", ALU_READY, 1);
      chk("sim.issue_ready", ISSUE_READY, 1);
      tick();
      ISSUE_VALID = 0;
      RA0 = 0; RA1 = 4;
      #1;
      chk("sim.hazard_held", HAZARD, 1);
      tick();
      ALU_VALID = 0;
      chk("sim.hazard_cleared", HAZARD, 0);
      chk("sim.sb_err", SB_ERR, 0);
      $display("seq issue+retire r4 done");

      // write-back to r7 with nothing pending
      MEM_VALID = 1; MEM_WA = 7; MEM_DATA = 32'h0000_0077; MEM_BE = 2'b11;
      tick();
      MEM_VALID = 0;
      RA0 = 7; RA1 = 7;
      #1;
      chk("err.sb_err_set", SB_ERR, 1);
      chk("err.hazard_r7", HAZARD, 0);
      tick();
      tick();
      chk("err.sb_err_sticky", SB_ERR, 1);
      $display("seq error r7 done");

      // asynchronous reset while the port is writing
      ISSUE_VALID = 1; ISSUE_WA = 1;
      tick();
      ISSUE_WA = 6;
      tick();
      ISSUE_VALID = 0;
      RA0 = 1; RA1 = 6;
      #1;
      chk("ar.hazard_before", HAZARD, 1);
      ALU_VALID = 1; ALU_WA = 3; ALU_DATA = 32'h0F0F_0F0F; ALU_BE = 2'b11;
      tick();
      ALU_VALID = 0;
      chk("ar.we_l_before", RF_WE_L, 1);
      chk("ar.we_h_before", RF_WE_H, 1);
      chk("ar.rf_wa_before", RF_WA, 3);
      chk("ar.sb_err_before", SB_ERR, 1);
      #2 RST = 1'b1;
      #1;
      chk("ar.we_l", RF_WE_L, 0);
      chk("ar.we_h", RF_WE_H, 0);
      chk("ar.sb_err", SB_ERR, 0);
      chk("ar.rf_wa", RF_WA, 0);
      chk("ar.rf_in", RF_IN, 0);
      chk("ar.hazard", HAZARD, 0);
      ALU_VALID = 1;
      #1;
      chk("ar.alu_ready_in_reset", ALU_READY, 1);
      ALU_VALID = 0;
      for (int r = 0; r < 8; r++) begin
         RA0 = 3'(r); RA1 = 3'(r); ISSUE_WA = 3'(r);
         #1;
         chk($sformatf("ar.hazard_r%0d", r), HAZARD, 0);
         chk($sformatf("ar.issue_ready_r%0d", r), ISSUE_READY, 1);
      end
      @(negedge CLK);
      RST = 1'b0;
      tick();
      $display("seq async reset done");

      // randomized run against the model
      reset_dut();
      model_reset();
      g = 0;
      for (int c = 0; c < 300; c++) begin
         if (!(ALU_VALID && g != 1)) begin
            ALU_VALID = ($urandom_range(0, 9) < 4);
            ALU_WA    = 3'($urandom_range(0, 3));
            ALU_DATA  = $urandom;
            ALU_BE    = 2'($urandom_range(0, 3));
         end
         if (!(MEM_VALID && g != 2)) begin
            MEM_VALID = ($urandom_range(0, 9) < 4);
            MEM_WA    = 3'($urandom_range(0, 3));
            MEM_DATA  = $urandom;
            MEM_BE    = 2'($urandom_range(0, 3));
         end
         ISSUE_VALID = 1'($urandom_range(0, 1));
         ISSUE_WA    = 3'($urandom_range(0, 3));
         RA0         = 3'($urandom_range(0, 7));
         RA1         = 3'($urandom_range(0, 7));
         run_cycle(c, g);
      end
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 8×32 register file. It arbitrates the regfile's single write port between the ALU and memory-load write-back requesters, and drives the regfile write address, data and halfword write-enables from registered outputs. It also keeps a per-register pending-write scoreboard that raises a read-hazard stall for the decode stage. It sits between the execute/memory stages and the regfile write port.

## Interface
Parameters:
- DATA_W, 32, write data width; the two halfword enables split it at DATA_W/2
- NREG, 8, number of registers
- AW, 3, register address width
- STARVE_MAX, 3, consecutive ALU losses before the ALU gets priority

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- ALU_VALID  in  1  ALU write-back request
- ALU_WA  in  AW  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_BE  in  2  halfword enables, [0]=low, [1]=high
- ALU_READY  out  1  ALU request accepted this cycle
- MEM_VALID, MEM_WA, MEM_DATA, MEM_BE, MEM_READY  same as the ALU set, for the load path
- ISSUE_VALID  in  1  an instruction with a destination register issues
- ISSUE_WA  in  AW  that destination register
- ISSUE_READY  out  1  the scoreboard can take the issue
- RA0, RA1  in  AW  decode read addresses
- HAZARD  out  1  RA0 or RA1 has a pending write
- RF_WA  out  AW  to regfile WA
- RF_IN  out  DATA_W  to regfile IN
- RF_WE_L, RF_WE_H  out  1  to regfile WE_L / WE_H
- SB_ERR  out  1  sticky: a write-back arrived for a register with a zero pending count

## Operation
- **Handshake.** A transfer happens on a posedge where VALID && READY. READY is combinational from both VALIDs and the arbiter state. The requester must hold WA, DATA and BE stable while VALID && !READY.
- **Arbitration.**
  - Only one valid: that one is granted.
  - Both valid: MEM wins, unless starve_cnt == STARVE_MAX, in which case ALU wins.
  - starve_cnt (2 bits) increments on each cycle the ALU loses a conflict. It clears on any ALU grant or any cycle with ALU_VALID low.
- **Output stage.** On a grant, the next posedge loads RF_WA, RF_IN, RF_WE_L = BE[0] and RF_WE_H = BE[1]. With no grant, the next posedge clears both WE outputs; RF_WA and RF_IN hold their values.
- **BE = 00.** The request is still accepted and still decrements the scoreboard, but no enable is driven.
- **Scoreboard.**
  - One 2-bit pending count per register.
  - ISSUE_VALID && ISSUE_READY increments cnt[ISSUE_WA].
  - A granted write-back decrements cnt[WA] on the same posedge.
  - Increment and decrement of the same register on one edge: count unchanged.
  - ISSUE_READY = (cnt[ISSUE_WA] != 3).
  - Write-back to a register whose count is 0: the count stays 0 and SB_ERR sets. SB_ERR clears only on RST.
- **Hazard.** HAZARD = (cnt[RA0] != 0) || (cnt[RA1] != 0), purely combinational.
- **Reset.** The async reset clears every count, starve_cnt, RF_WE_L/H, RF_WA, RF_IN and SB_ERR at any time, including mid-transfer. A request pending at reset must be re-presented after reset.

## Timing
- Acceptance edge t: the write is driven on RF_* during cycle t→t+1. The regfile commits it on the negedge inside that cycle.
- The scoreboard clears at edge t, so HAZARD drops during cycle t→t+1. A combinational regfile read sampled at edge t+1 returns the new value.
- Write latency is one cycle from acceptance to enables. Throughput is one write per cycle.
- Reset values: ALU_READY and MEM_READY follow the VALIDs (grant logic is combinational); ISSUE_READY=1; HAZARD=0; RF_WE_L=RF_WE_H=0; RF_WA=0; RF_IN=0; SB_ERR=0.

## Structure
- Shared package: AW, DATA_W, NREG, BE bit positions, and the requester encoding (REQ_NONE, REQ_ALU, REQ_MEM).
- Sub-module `wb_scoreboard`: the counter array, ISSUE_READY, HAZARD and SB_ERR.
- Arbiter and output stage stay in the top module.

## Test plan
- **Single ALU write.** ALU_VALID, WA=5, DATA=0xDEADBEEF, BE=11 → ALU_READY=1. The next cycle shows RF_WA=5, RF_IN=0xDEADBEEF, RF_WE_L=RF_WE_H=1; the cycle after shows both WE=0.
- **Conflict and starvation.** Hold both VALIDs for 5 cycles → MEM granted 3 times, ALU granted on the 4th cycle, MEM on the 5th.
- **Halfword write.** MEM BE=10, DATA=0x1234_5678 → RF_WE_H=1, RF_WE_L=0, RF_IN=0x12345678.
- **Scoreboard saturation and hazard.**
  - Issue WA=2 three times → cnt=3 and ISSUE_READY=0 for WA=2; RA0=2 gives HAZARD=1.
  - Three write-backs to r2 → HAZARD=0 in the cycle after the third acceptance.
- **Simultaneous issue and retire.** Issue WA=4 and write-back WA=4 on the same edge with cnt=1 → cnt stays 1, HAZARD stays 1 for RA1=4.
- **Error and reset.**
  - Write-back to r7 with cnt=0 → SB_ERR=1, and it remains set.
  - Assert RST asynchronously mid-cycle while both WE outputs are 1 → WE, SB_ERR and all counts go to 0 immediately.
